// File: rtl/imem_access_ctrl_if.sv
// Bus bundle between the instruction-memory controller, the IF stage, the loader and the memory.
// slave is the controller's view; master is the view of everything around it.
interface imem_access_ctrl_if;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rsp_valid;
  logic [31:0] if_instr;
  logic        if_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        core_hold;

  modport slave (
    input  if_req_valid, if_addr, ld_valid, ld_addr, ld_data, mem_rdata,
    output if_ready, if_rsp_valid, if_instr, if_err, ld_ready,
           mem_addr, mem_we, mem_wdata, core_hold
  );

  modport master (
    output if_req_valid, if_addr, ld_valid, ld_addr, ld_data, mem_rdata,
    input  if_ready, if_rsp_valid, if_instr, if_err, ld_ready,
           mem_addr, mem_we, mem_wdata, core_hold
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// Instruction-memory access controller: arbitrates IF fetches against loader word writes,
// splits loader words into four byte writes and keeps a starving fetch from waiting forever.
module imem_access_ctrl #(
  parameter int unsigned MEM_BYTES    = 512,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input logic               clk,
  input logic               rst_n,
  imem_access_ctrl_if.slave bus
);

  localparam int unsigned    SCW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0]    LAST_WORD  = 32'(MEM_BYTES - 4);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR0  = 3'd1;
  localparam logic [2:0] S_WR1  = 3'd2;
  localparam logic [2:0] S_WR2  = 3'd3;
  localparam logic [2:0] S_WR3  = 3'd4;

  logic [2:0]     r_state;
  logic [2:0]     w_state_nxt;
  logic [31:0]    r_waddr;
  logic [31:0]    r_wdata;
  logic [SCW-1:0] r_starve;
  logic [SCW-1:0] w_starve_nxt;
  logic           r_rsp_valid;
  logic           r_err;
  logic [31:0]    r_instr;

  logic           w_fetch_grant;
  logic           w_ld_grant;
  logic           w_fetch_err;
  logic [31:0]    w_ld_word;
  logic           w_ld_oor;
  logic [31:0]    w_maddr;
  logic           w_we;
  logic [7:0]     w_wdata;
  logic           w_hold;

  // Arbitration, memory drive and next state; grants only ever come out of IDLE
  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_grant = 1'b0;
    w_ld_grant    = 1'b0;
    w_maddr       = '0;
    w_we          = 1'b0;
    w_wdata       = '0;
    w_hold        = 1'b0;
    w_fetch_err   = (bus.if_addr[1:0] != 2'b00) || (bus.if_addr > LAST_WORD);
    w_ld_word     = bus.ld_addr & ~32'h0000_0003;
    w_ld_oor      = w_ld_word > LAST_WORD;

    case (r_state)
      S_IDLE: begin
        w_fetch_grant = bus.if_req_valid && (!bus.ld_valid || (r_starve >= STARVE_MAX));
        w_ld_grant    = bus.ld_valid && !w_fetch_grant;
        w_hold        = w_ld_grant;
        if (w_fetch_grant && !w_fetch_err) w_maddr = bus.if_addr;
        // an out-of-range loader word is acknowledged and dropped
        if (w_ld_grant && !w_ld_oor) w_state_nxt = S_WR0;
      end
      S_WR0: begin
        w_we        = 1'b1;
        w_hold      = 1'b1;
        w_maddr     = r_waddr;
        w_wdata     = r_wdata[7:0];
        w_state_nxt = S_WR1;
      end
      S_WR1: begin
        w_we        = 1'b1;
        w_hold      = 1'b1;
        w_maddr     = r_waddr + 32'd1;
        w_wdata     = r_wdata[15:8];
        w_state_nxt = S_WR2;
      end
      S_WR2: begin
        w_we        = 1'b1;
        w_hold      = 1'b1;
        w_maddr     = r_waddr + 32'd2;
        w_wdata     = r_wdata[23:16];
        w_state_nxt = S_WR3;
      end
      S_WR3: begin
        w_we        = 1'b1;
        w_hold      = 1'b1;
        w_maddr     = r_waddr + 32'd3;
        w_wdata     = r_wdata[31:24];
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Starvation counter: counts waiting cycles of a pending fetch, saturating
  always_comb begin
    w_starve_nxt = r_starve;
    if (!bus.if_req_valid || w_fetch_grant) w_starve_nxt = '0;
    else if (r_starve < STARVE_MAX)         w_starve_nxt = r_starve + SCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_starve    <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_instr     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_starve    <= w_starve_nxt;
      r_rsp_valid <= w_fetch_grant;
      if (w_ld_grant) begin
        r_waddr <= w_ld_word;
        r_wdata <= bus.ld_data;
      end
      if (w_fetch_grant) begin
        r_err   <= w_fetch_err;
        r_instr <= w_fetch_err ? NOP_INSTR : bus.mem_rdata;
      end else begin
        r_err   <= 1'b0;
      end
    end
  end

  assign bus.if_ready     = w_fetch_grant;
  assign bus.ld_ready     = w_ld_grant;
  assign bus.mem_addr     = w_maddr;
  assign bus.mem_we       = w_we;
  assign bus.mem_wdata    = w_wdata;
  assign bus.core_hold    = w_hold;
  assign bus.if_rsp_valid = r_rsp_valid;
  assign bus.if_err       = r_err;
  assign bus.if_instr     = r_instr;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl: directed vectors, multi-cycle corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_imem_access_ctrl;

  localparam int unsigned MEM_BYTES = 512;
  localparam int unsigned LIM       = 8;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clk;
  logic rst_n;
  imem_access_ctrl_if bus ();

  imem_access_ctrl #(
    .MEM_BYTES    (MEM_BYTES),
    .STARVE_LIMIT (LIM),
    .NOP_INSTR    (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory behind the controller, with a backdoor for preloading and clearing
  logic [7:0]  tbmem [MEM_BYTES];
  logic        bd_clr;
  logic        bd_we;
  logic [8:0]  bd_addr;
  logic [7:0]  bd_data;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) tbmem[i] <= 8'h00;
    end else if (bd_we) begin
      tbmem[bd_addr] <= bd_data;
    end else if (bus.mem_we && (bus.mem_addr < 32'(MEM_BYTES))) begin
      tbmem[bus.mem_addr[8:0]] <= bus.mem_wdata;
    end
  end

  always_comb begin
    if (bus.mem_addr <= 32'(MEM_BYTES - 4))
      bus.mem_rdata = {tbmem[bus.mem_addr[8:0] + 9'd3], tbmem[bus.mem_addr[8:0] + 9'd2],
                       tbmem[bus.mem_addr[8:0] + 9'd1], tbmem[bus.mem_addr[8:0]]};
    else
      bus.mem_rdata = 32'h0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bd_word(input logic [8:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      bd_we   = 1'b1;
      bd_addr = a + 9'(k);
      bd_data = w[8*k +: 8];
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
  endtask

  // Single fetch from an idle controller; entered and left at posedge+1
  task automatic fetch_chk(input string nm, input logic [31:0] a, input logic exp_err,
                           input logic [31:0] exp_instr);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = a;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(bus.if_ready), 32'd1);
    chk({nm, "_maddr"}, bus.mem_addr, exp_err ? 32'h0 : a);
    @(posedge clk); #1;
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_rsp"},   32'(bus.if_rsp_valid), 32'd1);
    chk({nm, "_err"},   32'(bus.if_err), 32'(exp_err));
    chk({nm, "_instr"}, bus.if_instr, exp_instr);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(bus.if_rsp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  // Full loader word write from an idle controller; entered and left at posedge+1
  task automatic load_word(input string nm, input logic [31:0] a, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    @(negedge clk);
    chk({nm, "_ldready"}, 32'(bus.ld_ready), 32'd1);
    chk({nm, "_hold0"},   32'(bus.core_hold), 32'd1);
    chk({nm, "_we_idle"}, 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s_we%0d", nm, k),    32'(bus.mem_we), 32'd1);
      chk($sformatf("%s_addr%0d", nm, k),  bus.mem_addr, (a & ~32'h3) + 32'(k));
      chk($sformatf("%s_data%0d", nm, k),  32'(bus.mem_wdata), 32'(d[8*k +: 8]));
      chk($sformatf("%s_hold%0d", nm, k),  32'(bus.core_hold), 32'd1);
      chk($sformatf("%s_noack%0d", nm, k), 32'(bus.ld_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({nm, "_hold_end"}, 32'(bus.core_hold), 32'd0);
    chk({nm, "_we_end"},   32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic        err;
    logic [31:0] instr;
  } fvec_t;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
  } wr_t;

  fvec_t      tv [7];
  logic [7:0] model_mem [MEM_BYTES];
  wr_t        wq [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, waited, fgrants;
    logic exp_f, exp_l, ifv, ldv, fg, lg, ferr;
    logic exp_rsp, exp_err;
    logic [31:0] exp_instr, fa, la, ld_w;
    wr_t w;

    tv[0] = '{"f_0x04",   32'h0000_0004, 1'b0, 32'h0010_0513};
    tv[1] = '{"f_mis06",  32'h0000_0006, 1'b1, NOP};
    tv[2] = '{"f_oor",    32'(MEM_BYTES), 1'b1, NOP};
    tv[3] = '{"f_last",   32'(MEM_BYTES - 4), 1'b0, 32'h1122_3344};
    tv[4] = '{"f_mis01",  32'h0000_0001, 1'b1, NOP};
    tv[5] = '{"f_hiaddr", 32'hFFFF_FFFC, 1'b1, NOP};
    tv[6] = '{"f_0x08",   32'h0000_0008, 1'b0, 32'h5566_7788};

    rst_n = 1'b0;
    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bd_clr = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    @(posedge clk); #1;
    bd_clr = 1'b0;

    @(negedge clk);
    chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
    chk("rst_rsp",      32'(bus.if_rsp_valid), 32'd0);
    chk("rst_instr",    bus.if_instr, 32'h0);
    chk("rst_err",      32'(bus.if_err), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_maddr",    bus.mem_addr, 32'h0);
    chk("rst_we",       32'(bus.mem_we), 32'd0);
    chk("rst_wdata",    32'(bus.mem_wdata), 32'd0);
    chk("rst_hold",     32'(bus.core_hold), 32'd0);
    @(posedge clk); #1;

    bd_word(9'h000, 32'h0A0B_0C0D);
    bd_word(9'h004, 32'h0010_0513);
    bd_word(9'h008, 32'h5566_7788);
    bd_word(9'(MEM_BYTES - 4), 32'h1122_3344);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) fetch_chk(tv[i].nm, tv[i].addr, tv[i].err, tv[i].instr);

    // back-to-back fetches
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h0;
    @(negedge clk);
    chk("b2b_rdy0", 32'(bus.if_ready), 32'd1);
    @(posedge clk); #1; bus.if_addr = 32'h4;
    @(negedge clk);
    chk("b2b_rdy1", 32'(bus.if_ready), 32'd1);
    chk("b2b_rsp0", 32'(bus.if_rsp_valid), 32'd1);
    chk("b2b_ins0", bus.if_instr, 32'h0A0B_0C0D);
    @(posedge clk); #1; bus.if_addr = 32'h8;
    @(negedge clk);
    chk("b2b_rdy2", 32'(bus.if_ready), 32'd1);
    chk("b2b_rsp1", 32'(bus.if_rsp_valid), 32'd1);
    chk("b2b_ins1", bus.if_instr, 32'h0010_0513);
    @(posedge clk); #1; bus.if_req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rsp2", 32'(bus.if_rsp_valid), 32'd1);
    chk("b2b_ins2", bus.if_instr, 32'h5566_7788);
    @(posedge clk); #1;

    load_word("ld20", 32'h0000_0020, 32'hDEAD_BEEF);
    fetch_chk("ld20_rd", 32'h20, 1'b0, 32'hDEAD_BEEF);

    // out-of-range loader word: acknowledged, nothing written
    bus.ld_valid = 1'b1; bus.ld_addr = 32'(MEM_BYTES) + 32'd2; bus.ld_data = 32'hCAFE_F00D;
    @(negedge clk);
    chk("ldoor_ready", 32'(bus.ld_ready), 32'd1);
    @(posedge clk); #1; bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("ldoor_we",   32'(bus.mem_we), 32'd0);
    chk("ldoor_hold", 32'(bus.core_hold), 32'd0);
    @(posedge clk); #1;

    // reset during WR2 aborts the burst, leaving bytes 0..1 written
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h40; bus.ld_data = 32'hA1B2_C3D4;
    @(negedge clk);
    chk("abort_grant", 32'(bus.ld_ready), 32'd1);
    @(posedge clk); #1; bus.ld_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("abort_wr2_we",   32'(bus.mem_we), 32'd1);
    chk("abort_wr2_addr", bus.mem_addr, 32'h42);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we_drop",   32'(bus.mem_we), 32'd0);
    chk("abort_hold_drop", 32'(bus.core_hold), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    fetch_chk("abort_partial", 32'h40, 1'b0, 32'h0000_C3D4);
    load_word("rewrite", 32'h0000_0043, 32'hA1B2_C3D4);
    fetch_chk("rewrite_rd", 32'h40, 1'b0, 32'hA1B2_C3D4);

    // sustained contention: loader every 5 cycles until the fetch has waited LIM cycles
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h4;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h80; bus.ld_data = 32'h0BAD_F00D;
    busy = 0; waited = 0; fgrants = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy > 0) begin
        exp_f = 1'b0; exp_l = 1'b0;
      end else if (waited >= int'(LIM)) begin
        exp_f = 1'b1; exp_l = 1'b0;
      end else begin
        exp_f = 1'b0; exp_l = 1'b1;
      end
      chk($sformatf("cont_if_ready_c%0d", c), 32'(bus.if_ready), 32'(exp_f));
      chk($sformatf("cont_ld_ready_c%0d", c), 32'(bus.ld_ready), 32'(exp_l));
      chk($sformatf("cont_hold_c%0d", c), 32'(bus.core_hold), 32'(busy > 0 || exp_l));
      if (busy > 0) busy--;
      if (exp_l) busy = 4;
      if (exp_f) fgrants++;
      waited = exp_f ? 0 : ((waited < int'(LIM)) ? waited + 1 : int'(LIM));
      @(posedge clk); #1;
    end
    chk("cont_fetch_grants", 32'(fgrants), 32'd18);
    bus.if_req_valid = 1'b0; bus.ld_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // randomized traffic vs. transaction model on a cleared memory
    bd_clr = 1'b1;
    @(posedge clk); #1;
    bd_clr = 1'b0;
    for (int i = 0; i < int'(MEM_BYTES); i++) model_mem[i] = 8'h00;
    waited = 0; exp_rsp = 1'b0; exp_err = 1'b0; exp_instr = '0;
    for (int c = 0; c < 600; c++) begin
      ifv = ($urandom_range(0, 3) != 0);
      ldv = ($urandom_range(0, 4) == 0);
      fa  = 32'($urandom_range(0, 530));
      if ($urandom_range(0, 3) != 0) fa = fa & ~32'h3;
      la  = 32'($urandom_range(0, 540));
      bus.if_req_valid = ifv; bus.if_addr = fa;
      bus.ld_valid = ldv; bus.ld_addr = la; bus.ld_data = $urandom;
      @(negedge clk);
      chk($sformatf("rnd_rsp_c%0d", c), 32'(bus.if_rsp_valid), 32'(exp_rsp));
      if (exp_rsp) begin
        chk($sformatf("rnd_err_c%0d", c), 32'(bus.if_err), 32'(exp_err));
        chk($sformatf("rnd_instr_c%0d", c), bus.if_instr, exp_instr);
      end
      fg = 1'b0; lg = 1'b0;
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk($sformatf("rnd_we_c%0d", c),    32'(bus.mem_we), 32'd1);
        chk($sformatf("rnd_waddr_c%0d", c), bus.mem_addr, 32'(w.a));
        chk($sformatf("rnd_wdata_c%0d", c), 32'(bus.mem_wdata), 32'(w.d));
        model_mem[w.a] = w.d;
      end else begin
        fg = ifv && (!ldv || waited >= int'(LIM));
        lg = ldv && !fg;
        chk($sformatf("rnd_we0_c%0d", c), 32'(bus.mem_we), 32'd0);
      end
      ferr = (fa % 4 != 0) || (fa > 32'(MEM_BYTES - 4));
      chk($sformatf("rnd_if_ready_c%0d", c), 32'(bus.if_ready), 32'(fg));
      chk($sformatf("rnd_ld_ready_c%0d", c), 32'(bus.ld_ready), 32'(lg));
      chk($sformatf("rnd_hold_c%0d", c), 32'(bus.core_hold), 32'(lg || (wq.size() > 0) || bus.mem_we));
      if (fg) chk($sformatf("rnd_faddr_c%0d", c), bus.mem_addr, ferr ? 32'h0 : fa);
      if (lg) begin
        ld_w = la - (la % 4);
        if (ld_w <= 32'(MEM_BYTES - 4))
          for (int k = 0; k < 4; k++) wq.push_back('{9'(ld_w + 32'(k)), bus.ld_data[8*k +: 8]});
      end
      exp_rsp = fg;
      exp_err = fg && ferr;
      if (fg)
        exp_instr = ferr ? NOP : {model_mem[9'(fa + 3)], model_mem[9'(fa + 2)],
                                  model_mem[9'(fa + 1)], model_mem[9'(fa)]};
      waited = (!ifv || fg) ? 0 : ((waited < int'(LIM)) ? waited + 1 : int'(LIM));
      @(posedge clk); #1;
    end
    bus.if_req_valid = 1'b0; bus.ld_valid = 1'b0;
    repeat (6) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
